serial2mem: RTL and testbench
=============================

Name: serial2mem

Overview:
- Receive side of the LPC capture serial link.
- Takes the byte stream produced by the capture-side transmitter: two 0xFF sync bytes followed by six payload bytes, LSB byte first.
- Re-assembles each 48-bit LPC frame and writes it to a frame buffer on the host/replay side.
- Sits between a UART receiver (one-cycle byte strobe) and a dual-port frame memory or FIFO.

Parameters:
- AW, 8, width of write_addr; frame buffer depth is 2^AW 48-bit words.
- TIMEOUT, 1000, max idle clock cycles between bytes inside a frame before resync; 0 disables the timeout.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- uart_data  input  8  received byte, valid only when uart_valid=1.
- uart_valid  input  1  one-cycle strobe per received byte.
- write_full  input  1  frame buffer cannot accept a word this cycle.
- clear_overflow  input  1  synchronous clear of the overflow flag.
- write_enable  output  1  one-cycle write strobe.
- write_data  output  48  assembled frame; stable while write_enable=1.
- write_addr  output  AW  word address for the current write; increments after each write.
- frame_count  output  16  number of frames written, wraps at 0xFFFF->0.
- overflow  output  1  sticky; a complete frame was dropped because write_full=1.
- sync_error  output  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (async, reset=0) values:
  - state=HUNT1, byte index=0, timeout counter=0.
  - write_enable=0, write_data=0, write_addr=0, frame_count=0, overflow=0, sync_error=0.
- States: HUNT1, HUNT2, PAYLOAD.
- HUNT1:
  - uart_valid with byte 0xFF -> HUNT2.
  - Any other byte is ignored; stay in HUNT1.
- HUNT2:
  - uart_valid with 0xFF -> PAYLOAD, index=0.
  - uart_valid with any other byte -> HUNT1, sync_error pulse.
- PAYLOAD:
  - Each uart_valid stores the byte into shift register bits [8*index+7 : 8*index], then index++.
  - 0xFF is legal payload data here; no sync search occurs inside PAYLOAD.
  - On the 6th byte (index 5), go to HUNT1 and commit the frame.
- Commit, evaluated in the cycle the 6th byte is accepted:
  - write_full=0: next cycle write_enable=1, write_data=assembled frame, write_addr=current address. The cycle after, write_addr++ (wraps 2^AW-1 -> 0) and frame_count++.
  - write_full=1: frame dropped, overflow<=1, no write, write_addr and frame_count unchanged.
  - Latency: 1 cycle from 6th uart_valid to write_enable.
  - No dead cycle: a byte arriving in the write_enable cycle is processed by HUNT1.
- Timeout (TIMEOUT>0):
  - Counter runs in HUNT2 and PAYLOAD on cycles without uart_valid; it is cleared by uart_valid and on entry to HUNT1.
  - When the counter reaches TIMEOUT: state->HUNT1, partial frame discarded, sync_error pulse, counter=0.
  - Never active in HUNT1.
- overflow:
  - Set wins over clear_overflow when both occur in the same cycle.
  - Otherwise clear_overflow=1 clears it.
- sync_error: single-cycle pulse; the two causes cannot coincide in one cycle.
- Reset mid-frame: partial frame lost, everything returns to reset values immediately; no write_enable glitch.
- write_data holds its last value when write_enable=0.

Test Plan:
- FF FF 01 02 03 04 05 06, write_full=0 -> write_enable one cycle after last byte, write_data=0x060504030201, write_addr=0, then write_addr=1, frame_count=1.
- FF FF FF FF FF FF FF FF -> payload of six 0xFF accepted, write_data=0xFFFFFFFFFFFF; a following 11 FF FF 22.. is resynced correctly (0x11 ignored in HUNT1).
- FF 3C FF FF A0 A1 A2 A3 A4 A5 -> sync_error pulse on 0x3C, then frame 0xA5A4A3A2A1A0 written.
- FF FF 01 02, then idle TIMEOUT=16 cycles -> sync_error pulse at cycle 16, no write; next full frame writes correctly at write_addr unchanged.
- Full frame with write_full=1 at commit -> no write_enable, overflow=1, frame_count unchanged; clear_overflow pulse -> overflow=0; clear coincident with new drop -> overflow stays 1.
- AW=2: write 5 frames -> addresses 0,1,2,3,0; assert reset=0 after 3 payload bytes -> all outputs zero asynchronously, no write.

Source files
------------

// File: rtl/serial2mem_if.sv
// Bundle of the byte-stream input and frame-buffer write port of serial2mem.
// The slave modport is the receiver's view; the master modport is the environment's.
interface serial2mem_if #(
  parameter int AW = 8
);
  logic [7:0]    uart_data;
  logic          uart_valid;
  logic          write_full;
  logic          clear_overflow;
  logic          write_enable;
  logic [47:0]   write_data;
  logic [AW-1:0] write_addr;
  logic [15:0]   frame_count;
  logic          overflow;
  logic          sync_error;

  modport master (
    output uart_data,
    output uart_valid,
    output write_full,
    output clear_overflow,
    input  write_enable,
    input  write_data,
    input  write_addr,
    input  frame_count,
    input  overflow,
    input  sync_error
  );

  modport slave (
    input  uart_data,
    input  uart_valid,
    input  write_full,
    input  clear_overflow,
    output write_enable,
    output write_data,
    output write_addr,
    output frame_count,
    output overflow,
    output sync_error
  );
endinterface

// File: rtl/serial2mem.sv
// Receive side of the LPC capture link: finds the FF FF sync pair, gathers six
// payload bytes (LSB byte first) into a 48-bit frame and writes it to the frame buffer.
module serial2mem #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic         clock,
  input  logic         reset,
  serial2mem_if.slave  bus
);

  typedef enum logic [1:0] {
    HUNT1   = 2'd0,
    HUNT2   = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [47:0]   shift_q, shift_d;
  logic          we_q, we_d;
  logic [47:0]   wdata_q, wdata_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          ovf_q, ovf_d;
  logic          serr_q, serr_d;

  logic byte_ff;
  logic lane_wr;
  logic last_byte;
  logic timeout_hit;

  assign byte_ff   = (bus.uart_data == 8'hFF);
  assign lane_wr   = (state_q == PAYLOAD) && bus.uart_valid;
  assign last_byte = lane_wr && (idx_q == 3'd5);

  // Idle-gap watchdog; only exists when a nonzero limit is configured.
  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int TW = $clog2(TIMEOUT + 1);
      localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

      logic [TW-1:0] tmo_q, tmo_d;

      assign timeout_hit = (state_q != HUNT1) && !bus.uart_valid && (tmo_q == TMO_LAST);

      always_comb begin
        tmo_d = tmo_q + TW'(1);
        if ((state_q == HUNT1) || bus.uart_valid || (state_d == HUNT1)) begin
          tmo_d = '0;
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          tmo_q <= '0;
        end else begin
          tmo_q <= tmo_d;
        end
      end
    end else begin : g_no_tmo
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // Byte lanes of the assembly register: lane gi takes the byte while idx points at it.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_lane
      assign shift_d[8*gi +: 8] = (lane_wr && (idx_q == 3'(gi))) ? bus.uart_data
                                                                 : shift_q[8*gi +: 8];
    end
  endgenerate

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT1: begin
        if (bus.uart_valid && byte_ff) begin
          state_d = HUNT2;
        end
      end
      HUNT2: begin
        if (bus.uart_valid) begin
          state_d = byte_ff ? PAYLOAD : HUNT1;
        end else if (timeout_hit) begin
          state_d = HUNT1;
        end
      end
      PAYLOAD: begin
        if (last_byte || timeout_hit) begin
          state_d = HUNT1;
        end
      end
      default: state_d = HUNT1;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    idx_d   = idx_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    waddr_d = waddr_q + AW'(we_q);
    fcnt_d  = fcnt_q + 16'(we_q);
    ovf_d   = ovf_q;
    serr_d  = timeout_hit || ((state_q == HUNT2) && bus.uart_valid && !byte_ff);

    if (lane_wr) begin
      idx_d = idx_q + 3'd1;
    end
    if (state_d != PAYLOAD) begin
      idx_d = 3'd0;
    end

    if (bus.clear_overflow) begin
      ovf_d = 1'b0;
    end
    if (last_byte) begin
      if (bus.write_full) begin
        ovf_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        wdata_d = shift_d;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q   <= 3'd0;
      shift_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      fcnt_q  <= '0;
      ovf_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      fcnt_q  <= fcnt_d;
      ovf_q   <= ovf_d;
      serr_q  <= serr_d;
    end
  end

  assign bus.write_enable = we_q;
  assign bus.write_data   = wdata_q;
  assign bus.write_addr   = waddr_q;
  assign bus.frame_count  = fcnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.sync_error   = serr_q;

endmodule

// File: tb/tb_serial2mem.sv
// Scoreboard bench for serial2mem: a byte-level model queues expected writes and
// sync errors; a negedge monitor pops and compares whenever the DUT emits one.
module tb_serial2mem;
  localparam int AW  = 2;
  localparam int TMO = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;

  serial2mem_if #(.AW(AW)) bus ();

  serial2mem #(.AW(AW), .TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            is_write;
    logic [47:0]   data;
    logic [AW-1:0] addr;
    logic [15:0]   fcnt;
  } ev_t;

  ev_t exp_q[$];

  // Reference model: sync search over whole bytes, frames as byte arrays.
  int          m_state;   // 0 = waiting first FF, 1 = waiting second FF, 2 = in payload
  int          m_idx;
  logic [47:0] m_frame;
  int unsigned m_writes;
  bit          m_ovf;

  function automatic void model_reset();
    m_state  = 0;
    m_idx    = 0;
    m_frame  = '0;
    m_writes = 0;
    m_ovf    = 1'b0;
  endfunction

  function automatic void push_serr();
    ev_t e;
    e.is_write = 1'b0;
    e.data     = '0;
    e.addr     = '0;
    e.fcnt     = '0;
    exp_q.push_back(e);
  endfunction

  function automatic void model_idle(input int n);
    if (m_state != 0 && n >= TMO) begin
      push_serr();
      m_state = 0;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit full, input bit clr);
    bit  set;
    ev_t e;
    set = 1'b0;
    case (m_state)
      0: if (b == 8'hFF) m_state = 1;
      1: begin
        if (b == 8'hFF) begin
          m_state = 2;
          m_idx   = 0;
        end else begin
          push_serr();
          m_state = 0;
        end
      end
      default: begin
        m_frame[8*m_idx +: 8] = b;
        m_idx++;
        if (m_idx == 6) begin
          m_state = 0;
          if (full) begin
            set = 1'b1;
          end else begin
            e.is_write = 1'b1;
            e.data     = m_frame;
            e.addr     = AW'(m_writes);
            e.fcnt     = 16'(m_writes);
            exp_q.push_back(e);
            m_writes++;
          end
        end
      end
    endcase
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endfunction

  // Called at posedge+1; leaves at posedge+1 after the byte's accepting edge.
  task automatic send(input logic [7:0] b, input int gap, input bit full, input bit clr);
    model_idle(gap);
    if (gap > 0) begin
      repeat (gap) @(posedge clock);
      #1;
    end
    bus.uart_data      = b;
    bus.uart_valid     = 1'b1;
    bus.write_full     = full;
    bus.clear_overflow = clr;
    model_byte(b, full, clr);
    @(posedge clock);
    #1;
    bus.uart_valid     = 1'b0;
    bus.write_full     = 1'b0;
    bus.clear_overflow = 1'b0;
    bus.uart_data      = 8'($urandom);
    chk("overflow_after_byte", bus.overflow, m_ovf);
  endtask

  logic [7:0] seq[$];

  task automatic send_seq();
    foreach (seq[i]) send(seq[i], 0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    model_idle(n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic int pick_gap();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 2);
    if (r == 7) return TMO - 1;
    if (r == 8) return TMO;
    return TMO + $urandom_range(1, 5);
  endfunction

  ev_t mon_e;
  always @(negedge clock) begin
    if (reset && (bus.write_enable || bus.sync_error)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: we=%0b serr=%0b data=%h while nothing expected",
                 bus.write_enable, bus.sync_error, bus.write_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_kind_is_write", bus.write_enable, mon_e.is_write);
        chk("event_serr", bus.sync_error, !mon_e.is_write);
        if (mon_e.is_write) begin
          chk("write_data", bus.write_data, mon_e.data);
          chk("write_addr", bus.write_addr, mon_e.addr);
          chk("frame_count_at_write", bus.frame_count, mon_e.fcnt);
        end
      end
    end
  end

  initial begin
    int          first;
    logic [15:0] fc_before;
    logic [7:0]  b;
    bit          full_last;

    bus.uart_data      = 8'h00;
    bus.uart_valid     = 1'b0;
    bus.write_full     = 1'b0;
    bus.clear_overflow = 1'b0;
    model_reset();

    #12;
    chk("rst_we", bus.write_enable, 0);
    chk("rst_wdata", bus.write_data, 0);
    chk("rst_addr", bus.write_addr, 0);
    chk("rst_fcnt", bus.frame_count, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_serr", bus.sync_error, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Basic frame and write latency
    seq = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_seq();
    chk("we_one_cycle_after_last", bus.write_enable, 1);
    chk("first_frame_data", bus.write_data, 48'h060504030201);
    chk("addr_during_write", bus.write_addr, 0);
    @(posedge clock);
    #1;
    chk("we_single_cycle", bus.write_enable, 0);
    chk("addr_after_write", bus.write_addr, 1);
    chk("fcnt_after_write", bus.frame_count, 1);
    chk("wdata_held", bus.write_data, 48'h060504030201);

    // All-FF payload, then resync past a stray byte
    seq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h11, 8'hFF, 8'hFF, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
    send_seq();

    // Broken sync pair
    seq = '{8'hFF, 8'h3C, 8'hFF, 8'hFF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_seq();

    // Idle timeout inside a frame
    seq = '{8'hFF, 8'hFF, 8'h01, 8'h02};
    send_seq();
    model_idle(40);
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (bus.sync_error && first == 0) first = k;
    end
    chk("timeout_latency", first, TMO);
    seq = '{8'hFF, 8'hFF, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    send_seq();

    // Overflow: drop, clear, clear coinciding with a drop
    idle(3);
    fc_before = bus.frame_count;
    seq = '{8'hFF, 8'hFF, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_seq();
    send(8'hC5, 0, 1'b1, 1'b0);
    idle(3);
    chk("fcnt_unchanged_on_drop", bus.frame_count, fc_before);
    bus.clear_overflow = 1'b1;
    @(posedge clock);
    #1;
    bus.clear_overflow = 1'b0;
    m_ovf = 1'b0;
    chk("overflow_cleared", bus.overflow, 0);
    send_seq();
    send(8'hC6, 0, 1'b1, 1'b1);
    chk("overflow_set_wins", bus.overflow, 1);

    // Randomised traffic
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 99) < 40) begin
        send(8'hFF, pick_gap(), 1'b0, ($urandom_range(0, 9) == 0));
        send(8'hFF, pick_gap(), 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) begin
          b = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
          full_last = (j == 5) && ($urandom_range(0, 9) == 0);
          send(b, pick_gap(), full_last, ($urandom_range(0, 9) == 0));
        end
      end else begin
        b = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
        send(b, pick_gap(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      end
    end
    idle(TMO + 4);
    chk("queue_empty_after_random", exp_q.size(), 0);

    // Asynchronous reset in the middle of a payload
    seq = '{8'hFF, 8'hFF, 8'hD0, 8'hD1, 8'hD2};
    send_seq();
    #3;
    reset = 1'b0;
    #1;
    chk("async_we", bus.write_enable, 0);
    chk("async_wdata", bus.write_data, 0);
    chk("async_addr", bus.write_addr, 0);
    chk("async_fcnt", bus.frame_count, 0);
    chk("async_ovf", bus.overflow, 0);
    chk("async_serr", bus.sync_error, 0);
    chk("nothing_pending_at_reset", exp_q.size(), 0);
    model_reset();
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    seq = '{8'hFF, 8'hFF, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
    send_seq();
    chk("post_reset_addr", bus.write_addr, 0);
    idle(TMO + 4);
    chk("queue_empty_at_end", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
